// File: rtl/muldiv_sequencer.sv
// HI/LO owner for EXE: iterative shift-add multiply and restoring divide (ITER edges), MTHI/MTLO and divide-by-zero in one edge.
// Define MULDIV_EARLY_OUT_EN to let multiply finish as soon as the remaining multiplier bits are all zero.
module muldiv_sequencer #(
  parameter int ITER = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        hilo_rd,
  input  logic        pipe_stall,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        done
);

  localparam int            CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   mcand_q, mcand_d;
  logic [31:0]   mplier_q, mplier_d;
  logic [63:0]   prod_q, prod_d;
  logic [31:0]   dvd_q, dvd_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [31:0]   rem_q, rem_d;
  logic          sign_q, sign_d;
  logic          rsign_q, rsign_d;

  logic        is_mt;
  logic        accept;
  logic        signed_op;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [63:0] prod_step, mul_res;
  logic        mul_last;
  logic [32:0] rem_shift, rem_trial;
  logic        q_bit;
  logic [31:0] rem_step, dvd_step, quo_res, rem_res;

  assign is_mt     = (op == OP_MTHI) || (op == OP_MTLO);
  assign busy      = (state_q != S_IDLE);
  assign stall_req = (busy && (hilo_rd || op_valid)) || (hilo_rd && op_valid && is_mt);
  assign accept    = op_valid && !pipe_stall && !stall_req && (state_q == S_IDLE);

  // Even opcodes among the muldiv group are the signed variants.
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & operand_a[31];
  assign b_neg     = signed_op & operand_b[31];
  assign a_abs     = a_neg ? (~operand_a + 32'd1) : operand_a;
  assign b_abs     = b_neg ? (~operand_b + 32'd1) : operand_b;

  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign mul_res   = sign_q ? (~prod_step + 64'd1) : prod_step;
`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last  = (cnt_q == LAST) || (mplier_q[31:1] == 31'd0);
`else
  assign mul_last  = (cnt_q == LAST);
`endif

  // Borrow out of the 33-bit trial subtract means the divisor did not fit.
  assign rem_shift = {rem_q, dvd_q[31]};
  assign rem_trial = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~rem_trial[32];
  assign rem_step  = q_bit ? rem_trial[31:0] : rem_shift[31:0];
  assign dvd_step  = {dvd_q[30:0], q_bit};
  assign quo_res   = sign_q  ? (~dvd_step + 32'd1) : dvd_step;
  assign rem_res   = rsign_q ? (~rem_step + 32'd1) : rem_step;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MTHI: hi_d = operand_a;
            OP_MTLO: lo_d = operand_a;
            OP_MULT, OP_MULTU: begin
              mcand_d  = {32'd0, a_abs};
              mplier_d = b_abs;
              prod_d   = 64'd0;
              cnt_d    = '0;
              sign_d   = a_neg ^ b_neg;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (operand_b == 32'd0) begin
                lo_d   = 32'hFFFF_FFFF;
                hi_d   = operand_a;
                done_d = 1'b1;
              end else begin
                dvd_d   = a_abs;
                dvs_d   = b_abs;
                rem_d   = 32'd0;
                cnt_d   = '0;
                sign_d  = a_neg ^ b_neg;
                rsign_d = a_neg;
                state_d = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        prod_d   = prod_step;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + CW'(1);
        if (mul_last) begin
          hi_d    = mul_res[63:32];
          lo_d    = mul_res[31:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_DIV: begin
        rem_d = rem_step;
        dvd_d = dvd_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          lo_d    = quo_res;
          hi_d    = rem_res;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      prod_q   <= 64'd0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 32'd0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign done   = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic reference model of HI/LO and busy duration.
module tb_muldiv_sequencer;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        hilo_rd = 1'b0;
  logic        pipe_stall = 1'b0;
  logic        stall_req, busy, done;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_sequencer #(.ITER(32)) dut (
    .CLK(CLK), .RESET(RESET), .op_valid(op_valid), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .hilo_rd(hilo_rd),
    .pipe_stall(pipe_stall), .stall_req(stall_req), .busy(busy),
    .hi_out(hi_out), .lo_out(lo_out), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (o == OP_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {hi, lo}: remainder over quotient, truncating division.
  function automatic logic [63:0] ref_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == OP_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_mul_lat(input logic [2:0] o, input logic [31:0] b);
    logic [31:0] m;
    int pos;
    m = (o == OP_MULT && b[31]) ? (~b + 32'd1) : b;
    pos = 0;
    for (int i = 0; i < 32; i++) if (m[i]) pos = i + 1;
    if (!EARLY) return 32;
    return (pos < 1) ? 1 : pos;
  endfunction

  // Offer one op (optionally first blocked by pipe_stall), then follow it to completion.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int lat, n;
    @(negedge CLK);
    op = o; operand_a = a; operand_b = b; op_valid = 1'b1; hilo_rd = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      pipe_stall = 1'b1;
      @(posedge CLK); #1;
      pipe_stall = 1'b0;
      @(negedge CLK);
      chk("pstall_busy", busy, 1'b0);
      chk("pstall_hi", hi_out, m_hi);
      chk("pstall_lo", lo_out, m_lo);
    end
    @(posedge CLK); #1;
    op_valid = 1'b0;
    @(negedge CLK);
    if (o == OP_MTHI || o == OP_MTLO || o > OP_MTLO) begin
      if (o == OP_MTHI) m_hi = a;
      if (o == OP_MTLO) m_lo = a;
      chk("mt_busy", busy, 1'b0);
      chk("mt_done", done, 1'b0);
      chk("mt_hi", hi_out, m_hi);
      chk("mt_lo", lo_out, m_lo);
    end else if ((o == OP_DIV || o == OP_DIVU) && b == 32'd0) begin
      r = ref_div(o, a, b);
      {m_hi, m_lo} = r;
      chk("dz_busy", busy, 1'b0);
      chk("dz_done", done, 1'b1);
      chk("dz_hi", hi_out, m_hi);
      chk("dz_lo", lo_out, m_lo);
      @(negedge CLK);
      chk("dz_done_clr", done, 1'b0);
    end else begin
      if (o == OP_MULT || o == OP_MULTU) begin
        r = ref_mul(o, a, b);
        lat = ref_mul_lat(o, b);
      end else begin
        r = ref_div(o, a, b);
        lat = 32;
      end
      n = 0;
      while (busy === 1'b1 && n < 200) begin
        chk("busy_stall", stall_req, hilo_rd);
        chk("busy_hi_hold", hi_out, m_hi);
        @(posedge CLK); #1;
        hilo_rd = 1'($urandom_range(0, 1));
        pipe_stall = 1'($urandom_range(0, 1));
        @(negedge CLK);
        n++;
      end
      {m_hi, m_lo} = r;
      chk("latency", n, lat);
      chk("cmp_done", done, 1'b1);
      chk("cmp_stall", stall_req, 1'b0);
      chk("cmp_hi", hi_out, m_hi);
      chk("cmp_lo", lo_out, m_lo);
      hilo_rd = 1'b0; pipe_stall = 1'b0;
      @(negedge CLK);
      chk("done_clr", done, 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a, b;
    logic [2:0] o;

    repeat (2) @(negedge CLK);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    RESET = 1'b1;

    do_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult_hi_k", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo_k", lo_out, 32'hFFFF_FFFA);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    chk("div_lo_k", lo_out, 32'hFFFF_FFFD);
    chk("div_hi_k", hi_out, 32'hFFFF_FFFF);
    do_op(OP_DIVU, 32'd100, 32'd7);
    chk("divu_lo_k", lo_out, 32'd14);
    chk("divu_hi_k", hi_out, 32'd2);
    do_op(OP_DIVU, 32'h0000_0064, 32'd0);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_lo_k", lo_out, 32'h8000_0000);
    chk("ovf_hi_k", hi_out, 32'd0);
    do_op(OP_MULTU, 32'h1234_5678, 32'h0000_0003);
    chk("eo_lo_k", lo_out, 32'h369D_0368);
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd0);

    // MFHI held across a multiply: stalls while busy, clear in the done cycle.
    @(negedge CLK);
    op = OP_MULTU; operand_a = 32'd5; operand_b = 32'd6; op_valid = 1'b1;
    @(posedge CLK); #1;
    op_valid = 1'b0; hilo_rd = 1'b1;
    @(negedge CLK);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      chk("rd_stall", stall_req, 1'b1);
      n++;
      @(negedge CLK);
    end
    chk("rd_lat", n, ref_mul_lat(OP_MULTU, 32'd6));
    chk("rd_stall_done", stall_req, 1'b0);
    chk("rd_done", done, 1'b1);
    chk("rd_lo", lo_out, 32'd30);
    chk("rd_hi", hi_out, 32'd0);
    hilo_rd = 1'b0;
    m_hi = 32'd0; m_lo = 32'd30;

    // MTLO presented while busy is held off, then applied in the first idle cycle.
    @(negedge CLK);
    op = OP_MULTU; operand_a = 32'd7; operand_b = 32'd9; op_valid = 1'b1;
    @(posedge CLK); #1;
    op = OP_MTLO; operand_a = 32'h0000_1234;
    @(negedge CLK);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      chk("mt_held_stall", stall_req, 1'b1);
      chk("mt_held_lo", lo_out, m_lo);
      n++;
      @(negedge CLK);
    end
    chk("mt_held_lat", n, ref_mul_lat(OP_MULTU, 32'd9));
    chk("mt_held_res", lo_out, 32'd63);
    chk("mt_held_free", stall_req, 1'b0);
    @(posedge CLK); #1;
    op_valid = 1'b0;
    @(negedge CLK);
    chk("mt_applied_lo", lo_out, 32'h0000_1234);
    chk("mt_applied_hi", hi_out, 32'd0);
    chk("mt_applied_busy", busy, 1'b0);
    m_lo = 32'h0000_1234; m_hi = 32'd0;

    // Reset ten iterations into a divide.
    do_op(OP_MULT, 32'hFFFF_0001, 32'h0001_FFFF);
    @(negedge CLK);
    op = OP_DIVU; operand_a = $urandom; operand_b = $urandom | 32'd1; op_valid = 1'b1;
    @(posedge CLK); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_hi", hi_out, 32'd0);
    chk("arst_lo", lo_out, 32'd0);
    chk("arst_done", done, 1'b0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge CLK);
    RESET = 1'b1;
    do_op(OP_DIVU, 32'd9, 32'd3);
    chk("post_rst_lo", lo_out, 32'd3);
    chk("post_rst_hi", hi_out, 32'd0);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 15));
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 1) == 0) a = a >> $urandom_range(0, 31);
      do_op(o, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
